instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 192 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: turns instruction descriptors into RV32I words and writes
// them to consecutive word addresses of an instruction memory, one word per
// two cycles, with session status reporting.
// Optional macro INSTR_ENCODER_IMM_CHECK_EN: when defined, out-of-range or
// misaligned immediates are rejected as illegal instead of being truncated.
module instr_encoder #(
  parameter int MAX_WORDS = 64,
  localparam int CW = $clog2(MAX_WORDS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op_type,
  input  logic [2:0]    alu_sel,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [31:0]   imm,
  input  logic          in_last,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] word_count
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WORDS - 1);

  state_t        state_q, state_d;
  logic [31:0]   ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          last_q, last_d;

  logic          imm12_ok;
  logic          immb_ok;
  logic          alu_ok;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic          enc_legal;
  logic [31:0]   enc_word;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
  // Immediates must fit the signed field exactly; branch offsets must also be even.
  assign imm12_ok = (imm[31:11] == {21{imm[11]}});
  assign immb_ok  = (imm[31:12] == {20{imm[12]}}) && !imm[0];
`else
  // Immediates are silently truncated to their field bits, so the upper bits are don't-care.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:13];
  assign imm12_ok = 1'b1;
  assign immb_ok  = 1'b1;
`endif

  // Decode the ALU selector into funct3/funct7 and flag unsupported operations.
  always_comb begin
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    alu_ok = 1'b1;
    case (alu_sel)
      3'b000: funct3 = 3'b000;
      3'b001: begin
        funct3 = 3'b000;
        funct7 = 7'b0100000;
      end
      3'b010: funct3 = 3'b111;
      3'b011: funct3 = 3'b110;
      3'b101: funct3 = 3'b010;
      default: alu_ok = 1'b0;
    endcase
  end

  // Build the RV32I word for the current descriptor and decide whether it is legal.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b0;
    case (op_type)
      3'b000: begin
        enc_legal = alu_ok;
        enc_word  = {funct7, rs2, rs1, funct3, rd, OP_R};
      end
      3'b001: begin
        // There is no immediate subtract in RV32I, so sub is rejected here.
        enc_legal = alu_ok && (alu_sel != 3'b001) && imm12_ok;
        enc_word  = {imm[11:0], rs1, funct3, rd, OP_I};
      end
      3'b010: begin
        enc_legal = imm12_ok;
        enc_word  = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
      end
      3'b011: begin
        enc_legal = imm12_ok;
        enc_word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
      end
      3'b100: begin
        enc_legal = immb_ok;
        enc_word  = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
      end
      default: begin
        enc_legal = 1'b0;
        enc_word  = 32'h0;
      end
    endcase
  end

  // Session sequencing: accept, write once, advance pointer, and decide when the session ends.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = RUN;
          ptr_d   = 32'h0;
          count_d = '0;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (enc_legal) begin
            wdata_d = enc_word;
            last_d  = in_last;
            state_d = WRITE;
          end else begin
            state_d = ERR;
          end
        end
      end
      WRITE: begin
        ptr_d   = ptr_q + 32'd4;
        count_d = count_q + 1'b1;
        if (last_q || (count_q == LAST_CNT)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 32'h0;
      count_q <= '0;
      wdata_q <= 32'h0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  // Outputs follow the state; reset forces them low immediately so a write in flight is dropped.
  always_comb begin
    in_ready   = !rst && (state_q == RUN);
    busy       = !rst && ((state_q == RUN) || (state_q == WRITE));
    mem_we     = !rst && (state_q == WRITE);
    done       = !rst && (state_q == DONE);
    err        = !rst && (state_q == ERR);
    mem_addr   = rst ? 32'h0 : ptr_q;
    mem_wdata  = rst ? 32'h0 : wdata_q;
    word_count = rst ? '0 : count_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder. Expected writes are
// queued as descriptors are driven and popped when a write strobe appears.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  op_type = 3'b000;
  logic [2:0]  alu_sel = 3'b000;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [31:0] imm = 32'h0;
  logic        in_last = 1'b0;

  logic        in_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [6:0]  word_count;

  logic        in_ready4, mem_we4, busy4, done4, err4;
  logic [31:0] mem_addr4, mem_wdata4;
  logic [2:0]  word_count4;

  int errors = 0;
  int checks = 0;
  bit sel4 = 1'b0;
  logic [63:0] exp_q[$];

  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op_type(op_type), .alu_sel(alu_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  instr_encoder #(.MAX_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
    .op_type(op_type), .alu_sel(alu_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .in_last(in_last), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .busy(busy4), .done(done4), .err(err4), .word_count(word_count4)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    logic        we;
    logic [63:0] got;
    logic [63:0] exp;
    we  = sel4 ? mem_we4 : mem_we;
    got = sel4 ? {mem_addr4, mem_wdata4} : {mem_addr, mem_wdata};
    if (we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: addr=%h data=%h, required no write", got[63:32], got[31:0]);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("[TB] FAIL write: addr=%h data=%h, required addr=%h data=%h",
                   got[63:32], got[31:0], exp[63:32], exp[31:0]);
        end
      end
    end
  end

  function automatic logic rdy();
    return sel4 ? in_ready4 : in_ready;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Drive one descriptor, wait for acceptance, and check the write strobe one cycle later.
  task automatic send(input logic [2:0] op, input logic [2:0] alu, input logic [4:0] rd_i,
                      input logic [4:0] rs1_i, input logic [4:0] rs2_i, input logic [31:0] imm_i,
                      input logic last_i, input bit exp_we, input logic [31:0] exp_addr,
                      input logic [31:0] exp_word);
    int n;
    op_type = op; alu_sel = alu; rd = rd_i; rs1 = rs1_i; rs2 = rs2_i; imm = imm_i;
    in_last = last_i; in_valid = 1'b1;
    n = 0;
    while (rdy() !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n == 20) begin
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready=%b, required 1 within 20 cycles", rdy());
      in_valid = 1'b0;
      in_last = 1'b0;
      return;
    end
    if (exp_we) exp_q.push_back({exp_addr, exp_word});
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    checks++;
    if ((sel4 ? mem_we4 : mem_we) !== exp_we) begin
      errors++;
      $display("[TB] FAIL latency_we: mem_we=%b, required %b", sel4 ? mem_we4 : mem_we, exp_we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    start = 1'b1;
    step(); step();
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata, word_count, in_ready, busy, done, err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: we=%b addr=%h data=%h cnt=%0d rdy=%b busy=%b done=%b err=%b, required all 0",
               mem_we, mem_addr, mem_wdata, word_count, in_ready, busy, done, err);
    end
    step();
    rst = 1'b0;
    start = 1'b0;
    step(); step();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_ready: in_ready=%b busy=%b, required 0 0", in_ready, busy);
    end
    in_valid = 1'b0;
    drain_check("reset");
  endtask

  task automatic test_single_add();
    pulse_start();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL run_status: in_ready=%b busy=%b, required 1 1", in_ready, busy);
    end
    send(3'b000, 3'b000, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 32'h0, 32'h002081B3);
    step();
    checks++;
    if (done !== 1'b1 || word_count !== 7'd1 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done: done=%b cnt=%0d rdy=%b, required 1 1 0", done, word_count, in_ready);
    end
    drain_check("single");
  endtask

  task automatic test_back_to_back();
    pulse_start();
    checks++;
    if (done !== 1'b0 || word_count !== 7'd0) begin
      errors++;
      $display("[TB] FAIL restart_clear: done=%b cnt=%0d, required 0 0", done, word_count);
    end
    send(3'b000, 3'b001, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0, 1'b1, 32'h0, 32'h407302B3);
    send(3'b010, 3'b000, 5'd2, 5'd1, 5'd0, 32'd8, 1'b0, 1'b1, 32'h4, 32'h0080A103);
    send(3'b011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd12, 1'b0, 1'b1, 32'h8, 32'h0020A623);
    send(3'b100, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hC, 32'hFE208EE3);
    step();
    checks++;
    if (done !== 1'b1 || word_count !== 7'd4) begin
      errors++;
      $display("[TB] FAIL seq_done: done=%b cnt=%0d, required 1 4", done, word_count);
    end
    drain_check("seq");
  endtask

  task automatic test_illegal();
    pulse_start();
    send(3'b101, 3'b000, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_op_err: err=%b rdy=%b busy=%b, required 1 0 0", err, in_ready, busy);
    end
    pulse_start();
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_clear: err=%b rdy=%b, required 0 1", err, in_ready);
    end
    send(3'b001, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h0, 32'h00500093);
    send(3'b001, 3'b001, 5'd1, 5'd2, 5'd0, 32'd5, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL isub_err: err=%b, required 1", err);
    end
    pulse_start();
    send(3'b000, 3'b100, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ralu_sel_err: err=%b, required 1", err);
    end
    drain_check("illegal");
  endtask

  task automatic test_alu_and_fields();
    pulse_start();
    send(3'b000, 3'b010, 5'd4, 5'd5, 5'd6, 32'h1234, 1'b0, 1'b1, 32'h0, 32'h0062F233);
    // start while running must not restart the session
    start = 1'b1;
    step();
    start = 1'b0;
    send(3'b000, 3'b011, 5'd4, 5'd5, 5'd6, 32'h0, 1'b0, 1'b1, 32'h4, 32'h0062E233);
    send(3'b000, 3'b101, 5'd4, 5'd5, 5'd6, 32'h0, 1'b0, 1'b1, 32'h8, 32'h0062A233);
    send(3'b001, 3'b011, 5'd7, 5'd8, 5'd19, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hC, 32'hFFF46393);
    send(3'b010, 3'b111, 5'd2, 5'd1, 5'd31, 32'd8, 1'b0, 1'b1, 32'h10, 32'h0080A103);
    send(3'b011, 3'b110, 5'd31, 5'd1, 5'd2, 32'd12, 1'b0, 1'b1, 32'h14, 32'h0020A623);
    send(3'b100, 3'b001, 5'd17, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h18, 32'hFE208EE3);
    step();
    checks++;
    if (done !== 1'b1 || word_count !== 7'd7) begin
      errors++;
      $display("[TB] FAIL fields_done: done=%b cnt=%0d, required 1 7", done, word_count);
    end
    drain_check("fields");
  endtask

  task automatic test_imm_range();
    pulse_start();
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    send(3'b001, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 1'b0, 32'h0, 32'h0);
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL imm_range_err: err=%b, required 1", err);
    end
`else
    send(3'b001, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 1'b1, 32'h0, 32'h80000093);
    step();
    checks++;
    if (err !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL imm_trunc_done: err=%b done=%b, required 0 1", err, done);
    end
`endif
    drain_check("imm");
  endtask

  task automatic test_reset_in_write();
    pulse_start();
    send(3'b000, 3'b000, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 32'h0, 32'h002081B3);
    step();
    op_type = 3'b000; alu_sel = 3'b001; rd = 5'd5; rs1 = 5'd6; rs2 = 5'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_write_we: mem_we=%b, required 0", mem_we);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata, word_count, in_ready, busy, done, err} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_write_after: we=%b addr=%h data=%h cnt=%0d rdy=%b busy=%b done=%b err=%b, required all 0",
               mem_we, mem_addr, mem_wdata, word_count, in_ready, busy, done, err);
    end
    drain_check("rst_write");
  endtask

  task automatic test_max_words();
    sel4 = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(3'b001, 3'b000, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0, 1'b1, 32'(4 * i),
           {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'b0010011});
    end
    op_type = 3'b001; alu_sel = 3'b000; rd = 5'd9; imm = 32'd9; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (in_ready4 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL max_fifth_ready: in_ready=%b, required 0", in_ready4);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done4 !== 1'b1 || word_count4 !== 3'd4) begin
      errors++;
      $display("[TB] FAIL max_done: done=%b cnt=%0d, required 1 4", done4, word_count4);
    end
    step();
    drain_check("max");
    sel4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_illegal();
    test_alu_and_fields();
    test_imm_range();
    test_reset_in_write();
    test_max_words();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
